// File: rtl/alu_rr_arbiter_if.sv
// alu_rr_arbiter_if
// Groups the two request channels, the two response channels, the ALU
// drive/return signals and the busy flag of alu_rr_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding issue logic, consumers and ALU.
interface alu_rr_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int OPW   = 3
);

  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;

  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;

  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;

  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    input  alu_result,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result,
    output rsp1_valid, rsp1_result,
    output alu_op, alu_a, alu_b,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    output alu_result,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result,
    input  rsp1_valid, rsp1_result,
    input  alu_op, alu_a, alu_b,
    input  busy
  );

endinterface

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
// Shares one combinational ALU between the execute stage (port 0) and
// address-gen (port 1). Only one operation is in flight at a time. The FSM
// walks IDLE -> EXEC -> RESP -> IDLE.
// The winner's operands are latched and driven to the ALU for one cycle.
// The result is then captured and held on the winner's response channel
// until the consumer takes it.
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN. When it is defined, port 0
// always wins a tie. When it is not defined, ties alternate round-robin.
module alu_rr_arbiter #(
  parameter int WIDTH = 64,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  alu_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_owner;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;

  logic             w_anyValid;
  logic             w_grantPort;
  logic             w_accept;
  logic             w_rspFire;

  assign w_anyValid = bus.req0_valid | bus.req1_valid;
  assign w_accept   = (r_state == S_IDLE) && w_anyValid && !rst;
  assign w_rspFire  = (r_state == S_RESP) &&
                      (r_owner ? bus.rsp1_ready : bus.rsp0_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Pick the winner: port 0 takes every tie, port 1 only wins when alone
  always_comb begin
    w_grantPort = 1'b0;
    if (!bus.req0_valid && bus.req1_valid) begin
      w_grantPort = 1'b1;
    end
  end
`else
  logic r_lastGrant;

  // Pick the winner: a lone requester wins, a tie goes to the port served less recently
  always_comb begin
    w_grantPort = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grantPort = ~r_lastGrant;
    end else if (bus.req1_valid) begin
      w_grantPort = 1'b1;
    end
  end

  // Remember who was served last; reset to 1 so port 0 takes the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastGrant <= 1'b1;
    end else if (w_rspFire) begin
      r_lastGrant <= r_owner;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus every output; outputs idle at zero outside their own state
  always_comb begin
    w_nextState     = r_state;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.rsp0_valid  = 1'b0;
    bus.rsp1_valid  = 1'b0;
    bus.rsp0_result = '0;
    bus.rsp1_result = '0;
    bus.alu_op      = '0;
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.busy        = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          bus.req0_ready = ~w_grantPort;
          bus.req1_ready = w_grantPort;
          w_nextState    = S_EXEC;
        end
      end

      S_EXEC: begin
        bus.alu_op  = r_op;
        bus.alu_a   = r_a;
        bus.alu_b   = r_b;
        w_nextState = S_RESP;
      end

      S_RESP: begin
        if (r_owner) begin
          bus.rsp1_valid  = 1'b1;
          bus.rsp1_result = r_result;
        end else begin
          bus.rsp0_valid  = 1'b1;
          bus.rsp0_result = r_result;
        end
        if (w_rspFire) begin
          w_nextState = S_IDLE;
        end
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Latch the winner's operands at the accept edge and capture the ALU result at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_owner <= w_grantPort;
        r_op    <= w_grantPort ? bus.req1_op : bus.req0_op;
        r_a     <= w_grantPort ? bus.req1_a  : bus.req0_a;
        r_b     <= w_grantPort ? bus.req1_b  : bus.req0_b;
      end
      if (r_state == S_EXEC) begin
        r_result <= bus.alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter
// Scoreboard bench for alu_rr_arbiter. The expected result of each request
// is queued per port when the request is driven. A cycle model of the
// arbiter predicts grants, ALU drive, busy and response timing, and pops
// the queue when the response is taken. Honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_rr_arbiter;

  localparam int WIDTH = 64;
  localparam int OPW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  alu_rr_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_rr_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
  } req_t;

  req_t        pend0[$];
  req_t        pend1[$];
  logic [63:0] expQ0[$];
  logic [63:0] expQ1[$];
  int          grantLog[$];

  int total = 0;
  int bad   = 0;

  bit hs0, hs1, acc0, acc1, randReady;

  int          mPhase;
  logic        mOwner;
  logic        mLastGrant;
  logic [2:0]  mOp;
  logic [63:0] mA;
  logic [63:0] mB;

  // Reference ALU; undefined op-codes get an arbitrary but distinctive result
  function automatic logic [63:0] aluRef(input logic [2:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return a + b;
      3'd4:    return a - b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // The ALU sitting behind the arbiter
  always_comb bus.alu_result = aluRef(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic [2:0] op,
                               input logic [63:0] a, input logic [63:0] b);
    req_t r;
    r.op = op;
    r.a  = a;
    r.b  = b;
    if (port == 0) pend0.push_back(r);
    else pend1.push_back(r);
  endtask

  task automatic loadPorts();
    req_t r;
    if (!bus.req0_valid && pend0.size() > 0) begin
      r = pend0.pop_front();
      bus.req0_op    = r.op;
      bus.req0_a     = r.a;
      bus.req0_b     = r.b;
      bus.req0_valid = 1'b1;
      expQ0.push_back(aluRef(r.op, r.a, r.b));
    end
    if (!bus.req1_valid && pend1.size() > 0) begin
      r = pend1.pop_front();
      bus.req1_op    = r.op;
      bus.req1_a     = r.a;
      bus.req1_b     = r.b;
      bus.req1_valid = 1'b1;
      expQ1.push_back(aluRef(r.op, r.a, r.b));
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    acc0 = hs0;
    acc1 = hs1;
    if (hs0) begin
      bus.req0_valid = 1'b0;
      hs0 = 1'b0;
    end
    if (hs1) begin
      bus.req1_valid = 1'b0;
      hs1 = 1'b0;
    end
    if (randReady) begin
      bus.rsp0_ready = 1'($urandom_range(0, 1));
      bus.rsp1_ready = 1'($urandom_range(0, 1));
    end
    loadPorts();
  endtask

  task automatic runUntilDrained(input int budget);
    int n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || bus.req0_valid || bus.req1_valid ||
            mPhase != 0) && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput("drainInBudget", 64'(n < budget), 64'd1);
    checkOutput("expQ0Left", 64'(expQ0.size()), 64'd0);
    checkOutput("expQ1Left", 64'(expQ1.size()), 64'd0);
  endtask

  task automatic applyReset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Cycle model: predicts every DUT output, then advances as the DUT should
  always @(negedge clk) begin : monitor
    logic        eValid;
    logic        ePort;
    logic [63:0] e0;
    logic [63:0] e1;
    if (rst) begin
      mPhase     = 0;
      mLastGrant = 1'b1;
      hs0        = 1'b0;
      hs1        = 1'b0;
    end else begin
      eValid = (mPhase == 0) && (bus.req0_valid || bus.req1_valid);
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        ePort = 1'b0;
`else
        ePort = ~mLastGrant;
`endif
      end else begin
        ePort = bus.req1_valid;
      end

      if (bus.req0_valid && bus.req0_ready) grantLog.push_back(0);
      if (bus.req1_valid && bus.req1_ready) grantLog.push_back(1);

      checkOutput("req0_ready", bus.req0_ready, 64'(eValid && !ePort));
      checkOutput("req1_ready", bus.req1_ready, 64'(eValid && ePort));
      checkOutput("busy", bus.busy, 64'(mPhase != 0));
      checkOutput("alu_op", bus.alu_op, (mPhase == 1) ? 64'(mOp) : 64'd0);
      checkOutput("alu_a", bus.alu_a, (mPhase == 1) ? mA : 64'd0);
      checkOutput("alu_b", bus.alu_b, (mPhase == 1) ? mB : 64'd0);

      e0 = 64'd0;
      e1 = 64'd0;
      if (mPhase == 2 && !mOwner) begin
        checkOutput("rsp0Expected", 64'(expQ0.size() > 0), 64'd1);
        if (expQ0.size() > 0) e0 = expQ0[0];
      end
      if (mPhase == 2 && mOwner) begin
        checkOutput("rsp1Expected", 64'(expQ1.size() > 0), 64'd1);
        if (expQ1.size() > 0) e1 = expQ1[0];
      end
      checkOutput("rsp0_valid", bus.rsp0_valid, 64'(mPhase == 2 && !mOwner));
      checkOutput("rsp1_valid", bus.rsp1_valid, 64'(mPhase == 2 && mOwner));
      checkOutput("rsp0_result", bus.rsp0_result, e0);
      checkOutput("rsp1_result", bus.rsp1_result, e1);

      case (mPhase)
        0: begin
          if (eValid) begin
            mOwner = ePort;
            mOp    = ePort ? bus.req1_op : bus.req0_op;
            mA     = ePort ? bus.req1_a  : bus.req0_a;
            mB     = ePort ? bus.req1_b  : bus.req0_b;
            mPhase = 1;
            if (ePort) hs1 = 1'b1;
            else hs0 = 1'b1;
          end
        end
        1: mPhase = 2;
        default: begin
          if (mOwner ? bus.rsp1_ready : bus.rsp0_ready) begin
            if (mOwner && expQ1.size() > 0) void'(expQ1.pop_front());
            if (!mOwner && expQ0.size() > 0) void'(expQ0.pop_front());
            mLastGrant = mOwner;
            mPhase     = 0;
          end
        end
      endcase
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int expPort;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_op    = '0;
    bus.req1_op    = '0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    randReady      = 1'b0;
    hs0            = 1'b0;
    hs1            = 1'b0;
    mPhase         = 0;
    mLastGrant     = 1'b1;

    // Reset state after two cycles of reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy", bus.busy, 64'd0);
    checkOutput("rstReq0Ready", bus.req0_ready, 64'd0);
    checkOutput("rstReq1Ready", bus.req1_ready, 64'd0);
    checkOutput("rstRsp0Valid", bus.rsp0_valid, 64'd0);
    checkOutput("rstRsp1Valid", bus.rsp1_valid, 64'd0);
    checkOutput("rstRsp0Result", bus.rsp0_result, 64'd0);
    checkOutput("rstRsp1Result", bus.rsp1_result, 64'd0);
    checkOutput("rstAluOp", bus.alu_op, 64'd0);
    checkOutput("rstAluA", bus.alu_a, 64'd0);
    checkOutput("rstAluB", bus.alu_b, 64'd0);
    rst = 1'b0;

    // Single XOR on port 0
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    applyStimulus(0, 3'd2, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    runUntilDrained(50);

    // Both ports contend from reset; grants must alternate, or favour port 0 under fixed priority
    applyReset(2);
    grantLog.delete();
    applyStimulus(0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_0F0F_0F0F);
    applyStimulus(1, 3'd2, 64'hDEAA_BEEE_CAAE_BEBE, 64'hDEAA_BEEE_CAAE_BEBE);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 3'($urandom_range(0, 4)), {$urandom, $urandom}, {$urandom, $urandom});
      applyStimulus(1, 3'($urandom_range(0, 4)), {$urandom, $urandom}, {$urandom, $urandom});
    end
    runUntilDrained(200);
    checkOutput("grantCount", 64'(grantLog.size()), 64'd8);
    for (int i = 0; i < grantLog.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      expPort = (i >= 4) ? 1 : 0;
`else
      expPort = i % 2;
`endif
      checkOutput($sformatf("grantOrder%0d", i), 64'(grantLog[i]), 64'(expPort));
    end

    // Port 1 ADD wraps to zero and is held under backpressure while port 0 waits
    bus.rsp1_ready = 1'b0;
    applyStimulus(1, 3'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (!acc1 && n < 20);
    checkOutput("holdAccepted", 64'(acc1), 64'd1);
    applyStimulus(0, 3'd1, {$urandom, $urandom}, {$urandom, $urandom});
    repeat (5) stepCycle();
    checkOutput("holdRsp1Valid", bus.rsp1_valid, 64'd1);
    checkOutput("holdRsp1Result", bus.rsp1_result, 64'd0);
    checkOutput("holdReq0Ready", bus.req0_ready, 64'd0);
    bus.rsp1_ready = 1'b1;
    runUntilDrained(50);

    // Reset during EXEC discards the operation without a response
    applyStimulus(0, 3'd4, {$urandom, $urandom}, {$urandom, $urandom});
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (!acc0 && n < 20);
    checkOutput("midAccepted", 64'(acc0), 64'd1);
    checkOutput("midBusyExec", bus.busy, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midBusy", bus.busy, 64'd0);
    checkOutput("midRsp0Valid", bus.rsp0_valid, 64'd0);
    checkOutput("midRsp0Result", bus.rsp0_result, 64'd0);
    checkOutput("midAluA", bus.alu_a, 64'd0);
    checkOutput("midAluOp", bus.alu_op, 64'd0);
    rst = 1'b0;
    expQ0.delete();
    repeat (8) stepCycle();

    // Random mix of ops, including undefined codes, with random consumer backpressure
    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, 1), 3'($urandom_range(0, 7)),
                    {$urandom, $urandom}, {$urandom, $urandom});
    end
    runUntilDrained(3000);
    randReady = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
